systolic_insertion_sorter: RTL and testbench

- Parametrised array of DEPTH insertion cells that sorts one frame of up to DEPTH keys, accepting one key per cycle and then streaming the frame out in sorted order at one key per cycle.
- Two phases: LOAD inserts keys in place; DRAIN pops keys from cell 0 and shifts the array up.
- Sort direction is selectable at build time, and equal keys keep arrival order (stable).
- Valid/ready handshakes on both sides let it sit between streaming producer and consumer blocks in the sort pipeline.

---
 rtl/systolic_insertion_sorter.sv | 157 +++++++++++++++
 tb/tb_systolic_insertion_sorter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_insertion_sorter.sv
// Systolic insertion sorter: LOAD inserts each key in place across DEPTH cells,
// DRAIN pops cell 0 and shifts the array up one key per cycle.
module systolic_insertion_sorter #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter bit DESCENDING = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_last,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         draining
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LP_DEPTH  = CW'(DEPTH);
  localparam logic [CW-1:0] LP_ONE    = CW'(1);

  typedef enum logic {
    ST_LOAD  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] r_data;
  logic [DEPTH-1:0]                 r_occ;
  logic [CW-1:0]                    r_count;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] w_data_nxt;
  logic [DEPTH-1:0]                 w_occ_nxt;
  logic [DEPTH-1:0]                 w_fits;
  logic [DEPTH-1:0]                 w_fits_below;
  logic                             w_accept;
  logic                             w_pop;
  logic                             w_in_ready;
  logic                             w_out_valid;
  logic                             w_out_last;

  // Handshake: a key moves on any edge where its valid and ready are both high;
  // ready/valid/last depend only on registered state, never on the peer's signal.
  assign w_in_ready  = (r_state == ST_LOAD) && (r_count < LP_DEPTH);
  assign w_out_valid = (r_state == ST_DRAIN) && (r_count != '0);
  assign w_out_last  = (r_state == ST_DRAIN) && (r_count == LP_ONE);
  assign w_accept    = in_valid && w_in_ready;
  assign w_pop       = w_out_valid && out_ready;

  // Occupied cells are contiguous from cell 0 and sorted, so fits is monotone:
  // the insertion point is the single cell where fits rises.
  assign w_fits_below = {w_fits[DEPTH-2:0], 1'b0};

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
    logic                  w_cmp;
    logic [DATA_WIDTH-1:0] w_from_below;
    logic                  w_occ_below;
    logic [DATA_WIDTH-1:0] w_from_above;
    logic                  w_occ_above;

    if (DESCENDING) begin : g_desc
      assign w_cmp = in_data > r_data[gi];
    end else begin : g_asc
      assign w_cmp = in_data < r_data[gi];
    end

    assign w_fits[gi] = !r_occ[gi] || w_cmp;

    if (gi == 0) begin : g_first
      assign w_from_below = '0;
      assign w_occ_below  = 1'b0;
    end else begin : g_mid_lo
      assign w_from_below = r_data[gi-1];
      assign w_occ_below  = r_occ[gi-1];
    end

    if (gi == DEPTH - 1) begin : g_last
      assign w_from_above = '0;
      assign w_occ_above  = 1'b0;
    end else begin : g_mid_hi
      assign w_from_above = r_data[gi+1];
      assign w_occ_above  = r_occ[gi+1];
    end

    always_comb begin
      w_data_nxt[gi] = r_data[gi];
      w_occ_nxt[gi]  = r_occ[gi];
      if (w_accept && w_fits[gi]) begin
        if (w_fits_below[gi]) begin
          w_data_nxt[gi] = w_from_below;
          w_occ_nxt[gi]  = w_occ_below;
        end else begin
          w_data_nxt[gi] = in_data;
          w_occ_nxt[gi]  = 1'b1;
        end
      end else if (w_pop) begin
        w_data_nxt[gi] = w_from_above;
        w_occ_nxt[gi]  = w_occ_above;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD: begin
        if (w_accept && (in_last || (r_count == LP_DEPTH - LP_ONE))) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_pop && w_out_last) begin
          w_state_nxt = ST_LOAD;
        end
      end
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_occ   <= '0;
      r_count <= '0;
    end else begin
      r_data <= w_data_nxt;
      r_occ  <= w_occ_nxt;
      if (w_accept) begin
        r_count <= r_count + LP_ONE;
      end else if (w_pop) begin
        r_count <= r_count - LP_ONE;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_last  = w_out_last;
  assign out_data  = r_data[0];
  assign count     = r_count;
  assign draining  = (r_state == ST_DRAIN);

endmodule

// File: tb/tb_systolic_insertion_sorter.sv
// Directed bench: ascending DEPTH=8 instance (index 0) and descending DEPTH=4
// instance (index 1) sharing clock and reset.
module tb_systolic_insertion_sorter;

  logic       clk;
  logic       reset_n;
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [7:0] in_data   [2];
  logic       in_last   [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic [7:0] out_data  [2];
  logic       out_last  [2];
  logic       draining  [2];
  logic [3:0] cnt       [2];
  logic [3:0] cnt_a;
  logic [2:0] cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q  [$];
  logic       exp_lq [$];

  logic       bp_ready [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] bp_data  [6] = '{8'd10, 8'd20, 8'd20, 8'd20, 8'd30, 8'd30};
  logic [3:0] bp_cnt   [6] = '{4'd3, 4'd2, 4'd2, 4'd2, 4'd1, 4'd1};

  assign cnt[0] = cnt_a;
  assign cnt[1] = {1'b0, cnt_b};

  systolic_insertion_sorter #(.DATA_WIDTH(8), .DEPTH(8), .DESCENDING(1'b0)) u_asc (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_last(in_last[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_last(out_last[0]), .count(cnt_a), .draining(draining[0])
  );

  systolic_insertion_sorter #(.DATA_WIDTH(8), .DEPTH(4), .DESCENDING(1'b1)) u_desc (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_last(in_last[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_last(out_last[1]), .count(cnt_b), .draining(draining[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // driver: present a key and hold it until accepted (in_valid left high)
  task automatic send(input int d, input logic [7:0] k, input logic l);
    int  t;
    logic done;
    t = 0;
    done = 1'b0;
    in_valid[d] = 1'b1;
    in_data[d]  = k;
    in_last[d]  = l;
    while (!done && t < 200) begin
      done = in_ready[d];
      step();
      t++;
    end
    check("send_accepted", done, 1);
  endtask

  task automatic expect_key(input logic [7:0] k, input logic l);
    exp_q.push_back(k);
    exp_lq.push_back(l);
  endtask

  // scoreboard drain: strict mode demands a key on every cycle and checks count
  task automatic drain(input int d, input int n, input logic strict);
    logic [7:0] ek;
    logic       el;
    out_ready[d] = 1'b1;
    for (int i = 0; i < n; i++) begin
      int t;
      t = 0;
      if (!strict) begin
        while (!out_valid[d] && t < 100) begin
          step();
          t++;
        end
      end
      check("out_valid", out_valid[d], 1);
      ek = exp_q.pop_front();
      el = exp_lq.pop_front();
      check("out_data", out_data[d], ek);
      check("out_last", out_last[d], el);
      if (strict) check("drain_count", cnt[d], n - i);
      step();
    end
    out_ready[d] = 1'b0;
  endtask

  task automatic check_idle(input int d, input string tag);
    check({tag, "_in_ready"}, in_ready[d], 1);
    check({tag, "_out_valid"}, out_valid[d], 0);
    check({tag, "_out_last"}, out_last[d], 0);
    check({tag, "_draining"}, draining[d], 0);
    check({tag, "_count"}, cnt[d], 0);
  endtask

  initial begin
    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_data[d] = '0; in_last[d] = 1'b0; out_ready[d] = 1'b0;
    end
    step();
    step();
    reset_n = 1'b1;
    step();

    // reset state
    for (int d = 0; d < 2; d++) begin
      check_idle(d, "rst");
      check("rst_out_data", out_data[d], 0);
    end

    // ascending sort, consecutive output
    send(0, 8'd5, 0); send(0, 8'd3, 0); send(0, 8'd9, 0); send(0, 8'd1, 0); send(0, 8'd7, 1);
    in_valid[0] = 1'b0; in_last[0] = 1'b0;
    check("asc_draining", draining[0], 1);
    check("asc_in_ready", in_ready[0], 0);
    check("asc_count", cnt[0], 5);
    expect_key(8'd1, 0); expect_key(8'd3, 0); expect_key(8'd5, 0);
    expect_key(8'd7, 0); expect_key(8'd9, 1);
    drain(0, 5, 1);
    check_idle(0, "asc_done");

    // descending with equal keys; last key also fills the array
    send(1, 8'd4, 0); send(1, 8'd4, 0); send(1, 8'd2, 0); send(1, 8'd4, 1);
    in_valid[1] = 1'b0; in_last[1] = 1'b0;
    check("dup_draining", draining[1], 1);
    expect_key(8'd4, 0); expect_key(8'd4, 0); expect_key(8'd4, 0); expect_key(8'd2, 1);
    drain(1, 4, 1);
    check_idle(1, "dup_done");

    // full auto-close without in_last
    send(1, 8'd2, 0); send(1, 8'd4, 0); send(1, 8'd6, 0); send(1, 8'd8, 0);
    in_valid[1] = 1'b0;
    check("full_in_ready", in_ready[1], 0);
    check("full_draining", draining[1], 1);
    check("full_count", cnt[1], 4);
    expect_key(8'd8, 0); expect_key(8'd6, 0); expect_key(8'd4, 0); expect_key(8'd2, 1);
    drain(1, 4, 1);
    check_idle(1, "full_done");

    // backpressure; a key offered during DRAIN must not be taken
    send(0, 8'd20, 0); send(0, 8'd10, 0); send(0, 8'd30, 1);
    in_valid[0] = 1'b1; in_data[0] = 8'h55; in_last[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      out_ready[0] = bp_ready[i];
      check("bp_out_valid", out_valid[0], 1);
      check("bp_out_data", out_data[0], bp_data[i]);
      check("bp_count", cnt[0], bp_cnt[i]);
      check("bp_out_last", out_last[0], (i >= 4) ? 1'b1 : 1'b0);
      step();
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b0;
    check_idle(0, "bp_done");

    // asynchronous reset mid-LOAD
    send(0, 8'd40, 0); send(0, 8'd50, 0); send(0, 8'd45, 0);
    in_valid[0] = 1'b0;
    check("pre_rst_count", cnt[0], 3);
    #3 reset_n = 1'b0;
    #1;
    check_idle(0, "async_rst");
    check("async_rst_out_data", out_data[0], 0);
    #2 reset_n = 1'b1;
    step();
    send(0, 8'd10, 0); send(0, 8'd0, 1);
    in_valid[0] = 1'b0; in_last[0] = 1'b0;
    expect_key(8'd0, 0); expect_key(8'd10, 1);
    drain(0, 2, 1);
    check_idle(0, "post_rst");

    // back-to-back frames with in_valid held high
    expect_key(8'd1, 0); expect_key(8'd2, 1);
    expect_key(8'd5, 0); expect_key(8'd6, 0); expect_key(8'd7, 1);
    fork
      begin
        send(0, 8'd2, 0); send(0, 8'd1, 1);
        send(0, 8'd7, 0); send(0, 8'd5, 0); send(0, 8'd6, 1);
        in_valid[0] = 1'b0; in_last[0] = 1'b0;
      end
      drain(0, 5, 0);
    join
    step();
    step();
    check_idle(0, "b2b_done");
    check("b2b_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
